// File: rtl/mdu_sequencer_if.sv
// Request/result bundle between the issuing pipeline stage (master) and the
// multiply/divide sequencer (slave).
interface mdu_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
);
    logic             op_valid;
    logic             op_ready;
    logic [OPW-1:0]   alu_operation;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output op_valid, alu_operation, a, b,
        input  op_ready, hi, lo, busy, done, div_by_zero
    );

    modport slave (
        input  op_valid, alu_operation, a, b,
        output op_ready, hi, lo, busy, done, div_by_zero
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Shift-add multiply / restoring divide for MULT(12)/DIV(13); result WIDTH+1 edges after accept,
// ready only in IDLE so requesters hold. MDU_SIGNED_EN selects two's-complement operands.
module mdu_sequencer #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mdu_sequencer_if.slave   bus
);

    localparam logic [OPW-1:0]   OP_MULT  = OPW'(12);
    localparam logic [OPW-1:0]   OP_DIV   = OPW'(13);
    localparam logic [WIDTH-1:0] CNT_INIT = WIDTH[WIDTH-1:0];
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_q, dbz_d;

    logic             is_mdu_op;
    logic             accept;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;

`ifdef MDU_SIGNED_EN
    assign sign_a = bus.a[WIDTH-1];
    assign sign_b = bus.b[WIDTH-1];
`else
    assign sign_a = 1'b0;
    assign sign_b = 1'b0;
`endif

    // With unsigned operands the sign flags are constant zero, so the same
    // magnitude and correction logic collapses to pass-through.
    assign mag_a = sign_a ? -bus.a : bus.a;
    assign mag_b = sign_b ? -bus.b : bus.b;

    assign is_mdu_op = (bus.alu_operation == OP_MULT) || (bus.alu_operation == OP_DIV);
    assign accept    = bus.op_valid && (state_q == S_IDLE) && is_mdu_op;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;

    assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign rem_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, opnd_q};

    logic [2*WIDTH-1:0] prod_mag, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign prod_mag = {acc_hi_q, acc_lo_q};
    assign prod_fix = neg_res_q ? -prod_mag : prod_mag;
    assign quot_fix = neg_res_q ? -acc_lo_q : acc_lo_q;
    assign rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opnd_d    = opnd_q;
        a_raw_d   = a_raw_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_RUN;
                    cnt_d     = CNT_INIT;
                    is_div_d  = (bus.alu_operation == OP_DIV);
                    neg_res_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    dbz_d     = (bus.alu_operation == OP_DIV) && (bus.b == '0);
                    a_raw_d   = bus.a;
                    acc_hi_d  = '0;
                    if (bus.alu_operation == OP_DIV) begin
                        acc_lo_d = mag_a;
                        opnd_d   = mag_b;
                    end else begin
                        acc_lo_d = mag_b;
                        opnd_d   = mag_a;
                    end
                end
            end

            S_RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (is_div_q) begin
                    // Borrow out of the WIDTH+1-bit trial subtract means the
                    // divisor did not fit: keep the shifted remainder.
                    if (!rem_diff[WIDTH]) begin
                        acc_hi_d = rem_diff[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_d = rem_sh[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                state_d = S_DONE;
                if (dbz_q) begin
                    hi_d = a_raw_q;
                    lo_d = '1;
                end else if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            a_raw_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opnd_q    <= opnd_d;
            a_raw_q   <= a_raw_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
        end
    end

    assign bus.op_ready    = (state_q == S_IDLE);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed vector bench for mdu_sequencer; expectations follow MDU_SIGNED_EN.
module tb_mdu_sequencer;

    localparam logic [3:0] MULT = 4'd12;
    localparam logic [3:0] DIV  = 4'd13;
    localparam int         LAT  = 33;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mdu_sequencer_if #(.WIDTH(32), .OPW(4)) bus ();

    mdu_sequencer #(.WIDTH(32), .OPW(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dbz);
        int cyc;
        logic busy_gap;
        @(negedge clk);
        bus.op_valid      = 1'b1;
        bus.alu_operation = op;
        bus.a             = a;
        bus.b             = b;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        check({tag, " busy after accept"}, 64'(bus.busy), 64'(1'b1));
        check({tag, " dbz after accept"}, 64'(bus.div_by_zero), 64'(exp_dbz));
        cyc      = 0;
        busy_gap = 1'b0;
        while (!bus.done && cyc < 100) begin
            if (!bus.busy) busy_gap = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'(LAT));
        check({tag, " busy held"}, 64'(busy_gap), 64'(1'b0));
        check({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
        check({tag, " dbz"}, 64'(bus.div_by_zero), 64'(exp_dbz));
        @(posedge clk);
        #1;
        check({tag, " ready after done"}, 64'({bus.op_ready, bus.done}), 64'(2'b10));
    endtask

    vec_t vecs[11];

    initial begin
        int  cyc;
        logic bad;

        bus.op_valid      = 1'b0;
        bus.alu_operation = 4'd0;
        bus.a             = '0;
        bus.b             = '0;

`ifdef MDU_SIGNED_EN
        vecs[0]  = '{MULT, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{DIV,  32'hFFFFFF9C,   32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0};
        vecs[3]  = '{MULT, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
        vecs[6]  = '{DIV,  32'h80000000,   32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0};
        vecs[9]  = '{MULT, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h0,        32'h1,        1'b0};
`else
        vecs[0]  = '{MULT, 32'd7,          32'hFFFFFFFD, 32'h6,        32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{DIV,  32'hFFFFFF9C,   32'd7,        32'h2,        32'h24924916, 1'b0};
        vecs[3]  = '{MULT, 32'hFFFFFFFF,   32'd2,        32'h1,        32'hFFFFFFFE, 1'b0};
        vecs[6]  = '{DIV,  32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'h0,        1'b0};
        vecs[9]  = '{MULT, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1,        1'b0};
`endif
        vecs[1]  = '{DIV,  32'd100,        32'd7,        32'd2,        32'd14,       1'b0};
        vecs[4]  = '{DIV,  32'h1234,       32'h0,        32'h1234,     32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{MULT, 32'h10000,      32'h10000,    32'h1,        32'h0,        1'b0};
        vecs[7]  = '{MULT, 32'h0,          32'h12345678, 32'h0,        32'h0,        1'b0};
        vecs[8]  = '{DIV,  32'hFFFFFFFF,   32'd1,        32'h0,        32'hFFFFFFFF, 1'b0};
        vecs[10] = '{DIV,  32'd12345,      32'd100,      32'd45,       32'd123,      1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset op_ready", 64'(bus.op_ready), 64'(1'b1));
        check("reset busy", 64'(bus.busy), 64'(1'b0));
        check("reset done", 64'(bus.done), 64'(1'b0));
        check("reset dbz", 64'(bus.div_by_zero), 64'(1'b0));
        check("reset hi", 64'(bus.hi), 64'(32'h0));
        check("reset lo", 64'(bus.lo), 64'(32'h0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].dbz);
        end

        // Non-MDU code must be ignored while presented
        @(negedge clk);
        bus.op_valid      = 1'b1;
        bus.alu_operation = 4'd8;
        bus.a             = 32'h55;
        bus.b             = 32'h3;
        bad = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (!bus.op_ready || bus.busy || bus.done) bad = 1'b1;
        end
        check("op8 no state change", 64'(bad), 64'(1'b0));
        check("op8 hi held", 64'(bus.hi), 64'(vecs[10].hi));
        check("op8 lo held", 64'(bus.lo), 64'(vecs[10].lo));
        bus.op_valid = 1'b0;

        // Backpressure: second MULT held from the cycle after the first accept
        @(negedge clk);
        bus.op_valid      = 1'b1;
        bus.alu_operation = MULT;
        bus.a             = 32'd3;
        bus.b             = 32'd5;
        @(posedge clk);
        #1;
        bus.a = 32'd6;
        bus.b = 32'd7;
        cyc = 0;
        bad = 1'b0;
        while (!bus.done && cyc < 100) begin
            if (bus.op_ready) bad = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("bp first latency", 64'(cyc), 64'(LAT));
        check("bp ready low while busy", 64'(bad), 64'(1'b0));
        check("bp ready low at done", 64'(bus.op_ready), 64'(1'b0));
        check("bp first lo", 64'({bus.hi, bus.lo}), 64'(15));
        @(posedge clk);
        #1;
        check("bp ready after done", 64'(bus.op_ready), 64'(1'b1));
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        check("bp second accepted", 64'(bus.busy), 64'(1'b1));
        repeat (LAT - 1) @(posedge clk);
        #1;
        check("bp result held pre-FIX", 64'({bus.hi, bus.lo}), 64'(15));
        check("bp done not early", 64'(bus.done), 64'(1'b0));
        @(posedge clk);
        #1;
        check("bp second done", 64'(bus.done), 64'(1'b1));
        check("bp second result", 64'({bus.hi, bus.lo}), 64'(42));
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a DIV
        @(negedge clk);
        bus.op_valid      = 1'b1;
        bus.alu_operation = DIV;
        bus.a             = 32'd100;
        bus.b             = 32'd7;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst op_ready", 64'(bus.op_ready), 64'(1'b1));
        check("arst busy", 64'(bus.busy), 64'(1'b0));
        check("arst done", 64'(bus.done), 64'(1'b0));
        check("arst hi/lo", 64'({bus.hi, bus.lo}), 64'(0));
        @(posedge clk);
        #1;
        check("arst no done", 64'(bus.done), 64'(1'b0));
        #2;
        rst = 1'b0;
        run_op("post-reset mult", MULT, 32'h10000, 32'd3, 32'h0, 32'h30000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
